// File: rtl/ct_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ct_bus_pkg
// Description : Shared types and constants for the compute-tile bus watchdog.
//               Holds the watchdog FSM state encoding, the Wishbone cycle-type
//               (CTI) codes, the default timeout and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ct_bus_pkg;

    // Watchdog FSM state encoding (explicit 2-bit width)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } bus_state_e;

    // Wishbone registered-feedback cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Cycles a strobe may wait for a response unless overridden
    localparam int TIMEOUT_DEFAULT = 255;

    // Counter width able to hold 0..timeout, never narrower than one bit
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ct_bus_timeout_if.sv
`default_nettype none
// ============================================================================
// Module      : ct_bus_timeout_if
// Description : Wishbone bus bundle between a bus master and a bus slave.
//               Request signals flow master -> slave, response signals flow
//               slave -> master.
//                 dat_w  [31:0] write data        (request)
//                 adr    [31:0] address           (request)
//                 sel    [3:0]  byte selects      (request)
//                 we            write enable      (request)
//                 cyc           bus cycle         (request)
//                 stb           strobe            (request)
//                 cti    [2:0]  cycle type        (request)
//                 bte    [1:0]  burst type        (request)
//                 ack/err/rty   termination       (response)
//                 dat_r  [31:0] read data         (response)
//               modport master : the side that issues requests
//               modport slave  : the side that answers requests
// Revision    : 1.0 - initial release
// ============================================================================
interface ct_bus_timeout_if;

    logic [31:0] dat_w;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] dat_r;

    modport master (
        output dat_w, adr, sel, we, cyc, stb, cti, bte,
        input  ack, err, rty, dat_r
    );

    modport slave (
        input  dat_w, adr, sel, we, cyc, stb, cti, bte,
        output ack, err, rty, dat_r
    );

endinterface
`default_nettype wire

// File: rtl/ct_bus_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ct_bus_timeout_cnt
// Description : Saturating up-counter with synchronous clear and count enable.
//               Clear has priority over enable. The count stops at MAX and
//               tc_o flags that the terminal count has been reached.
//   Ports:
//     clk     in   clock
//     rst_n   in   asynchronous active-low reset (count -> 0)
//     clr     in   synchronous clear to 0
//     en      in   count enable
//     tc_o    out  count equals MAX
// Revision    : 1.0 - initial release
// ============================================================================
module ct_bus_timeout_cnt #(
    parameter int CNT_W = 8,
    parameter int MAX   = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != c_max_cnt)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == c_max_cnt);

endmodule
`default_nettype wire

// File: rtl/ct_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module      : ct_bus_timeout
// Description : Wishbone watchdog between the CPU data master and the tile
//               address-select stage. Requests pass straight through. A strobe
//               left unanswered for TIMEOUT cycles is terminated with a
//               one-cycle error to the master, after which the downstream bus
//               is fenced until the master ends its cycle. TIMEOUT = 0 turns
//               the block into a pure pass-through.
//   Ports:
//     clk          in   tile clock
//     rst_n        in   asynchronous active-low reset
//     m_bus        if   slave modport, faces the CPU master (m_* signals)
//     s_bus        if   master modport, faces the select stage (s_* signals)
//     timeout_o    out  one-cycle pulse coincident with the generated error
//     err_adr_o    out  address of the last timed-out access
//     err_we_o     out  write enable of the last timed-out access
//     err_valid_o  out  capture register holds data
//     err_clear_i  in   clears err_valid_o
//   Build option:
//     CT_BUS_TIMEOUT_ERRCAPTURE_EN - enables the timed-out access capture
//     register; without it the err_* outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_bus_timeout
    import ct_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    ct_bus_timeout_if.slave     m_bus,
    ct_bus_timeout_if.master    s_bus,
    output logic                timeout_o,
    output logic [31:0]         err_adr_o,
    output logic                err_we_o,
    output logic                err_valid_o,
    input  logic                err_clear_i
);

    localparam int CNT_W    = cnt_width(TIMEOUT);
    localparam bit c_wd_en  = (TIMEOUT != 0);

    bus_state_e state_d;
    bus_state_e state_q;

    logic w_req;
    logic w_resp;
    logic w_fence;
    logic w_abort;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_cnt_tc;

    assign w_req  = m_bus.cyc & m_bus.stb;
    assign w_resp = s_bus.ack | s_bus.err | s_bus.rty;

    // ------------------------------------------------------------------
    // Wait counter
    // ------------------------------------------------------------------
    ct_bus_timeout_cnt #(
        .CNT_W (CNT_W),
        .MAX   (TIMEOUT)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .tc_o  (w_cnt_tc)
    );

    // ------------------------------------------------------------------
    // Watchdog FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        w_cnt_clr = 1'b1;
        w_cnt_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The first unanswered strobe cycle counts as cycle 1
                if (w_req && !w_resp) begin
                    state_d   = ST_WAIT;
                    w_cnt_clr = 1'b0;
                    w_cnt_en  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_resp) begin
                    // A response always beats expiry; a held strobe is the
                    // next burst beat and keeps us watching from zero
                    state_d = w_req ? ST_WAIT : ST_IDLE;
                end else if (!w_req) begin
                    state_d = ST_IDLE;
                end else if (w_cnt_tc) begin
                    state_d = ST_ABORT;
                end else begin
                    w_cnt_clr = 1'b0;
                    w_cnt_en  = 1'b1;
                end
            end
            ST_ABORT: begin
                // Master already gone: no need to drain
                state_d = m_bus.cyc ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (!m_bus.cyc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!c_wd_en) begin
            state_d   = ST_IDLE;
            w_cnt_clr = 1'b1;
            w_cnt_en  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: forward requests, fence and gate responses
    // ------------------------------------------------------------------
    assign w_abort = (state_q == ST_ABORT);
    assign w_fence = (state_q == ST_ABORT) || (state_q == ST_DRAIN);

    assign s_bus.dat_w = m_bus.dat_w;
    assign s_bus.adr   = m_bus.adr;
    assign s_bus.sel   = m_bus.sel;
    assign s_bus.we    = m_bus.we;
    assign s_bus.cti   = m_bus.cti;
    assign s_bus.bte   = m_bus.bte;
    assign s_bus.cyc   = m_bus.cyc & ~w_fence;
    assign s_bus.stb   = m_bus.stb & ~w_fence;

    // Late slave responses are swallowed while fenced
    assign m_bus.ack   = s_bus.ack & ~w_fence;
    assign m_bus.rty   = s_bus.rty & ~w_fence;
    assign m_bus.err   = w_abort | (s_bus.err & ~w_fence);
    assign m_bus.dat_r = w_fence ? 32'd0 : s_bus.dat_r;

    assign timeout_o   = w_abort;

    // ------------------------------------------------------------------
    // Timed-out access capture
    // ------------------------------------------------------------------
`ifdef CT_BUS_TIMEOUT_ERRCAPTURE_EN
    logic [31:0] err_adr_d;
    logic [31:0] err_adr_q;
    logic        err_we_d;
    logic        err_we_q;
    logic        err_valid_d;
    logic        err_valid_q;
    logic        w_enter_abort;

    assign w_enter_abort = (state_q == ST_WAIT) && (state_d == ST_ABORT);

    always_comb begin
        err_adr_d   = err_adr_q;
        err_we_d    = err_we_q;
        err_valid_d = err_valid_q;
        // A new timeout outranks a simultaneous clear
        if (w_enter_abort) begin
            err_adr_d   = m_bus.adr;
            err_we_d    = m_bus.we;
            err_valid_d = 1'b1;
        end else if (err_clear_i) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_adr_q   <= '0;
            err_we_q    <= 1'b0;
            err_valid_q <= 1'b0;
        end else begin
            err_adr_q   <= err_adr_d;
            err_we_q    <= err_we_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign err_adr_o   = err_adr_q;
    assign err_we_o    = err_we_q;
    assign err_valid_o = err_valid_q;
`else
    logic w_unused_err_clear;

    assign w_unused_err_clear = err_clear_i;
    assign err_adr_o          = 32'd0;
    assign err_we_o           = 1'b0;
    assign err_valid_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ct_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_bus_timeout
// Description : Self-checking bench for ct_bus_timeout. A TIMEOUT = 8 instance
//               is driven from a per-cycle vector table, followed by directed
//               sequences for capture, clear collision and asynchronous reset.
//               A TIMEOUT = 0 instance is held with a silent slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_bus_timeout;
    import ct_bus_pkg::*;

    localparam logic [31:0] SDAT  = 32'hDEAD_BEEF;
    localparam logic [31:0] MDAT  = 32'hCAFE_0001;
    localparam logic [31:0] ADR_A = 32'h7000_0040;
    localparam logic [31:0] ADR_B = 32'h1234_5678;
    localparam logic [3:0]  SEL   = 4'hA;
    localparam logic [1:0]  BTE   = 2'b01;

`ifdef CT_BUS_TIMEOUT_ERRCAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ct_bus_timeout_if m8 ();
    ct_bus_timeout_if s8 ();
    ct_bus_timeout_if m0 ();
    ct_bus_timeout_if s0 ();

    logic        to8, we8, valid8, clr8;
    logic [31:0] adr8;
    logic        to0, we0, valid0, clr0;
    logic [31:0] adr0;

    ct_bus_timeout #(.TIMEOUT(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_bus       (m8),
        .s_bus       (s8),
        .timeout_o   (to8),
        .err_adr_o   (adr8),
        .err_we_o    (we8),
        .err_valid_o (valid8),
        .err_clear_i (clr8)
    );

    ct_bus_timeout #(.TIMEOUT(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_bus       (m0),
        .s_bus       (s0),
        .timeout_o   (to0),
        .err_adr_o   (adr0),
        .err_we_o    (we0),
        .err_valid_o (valid0),
        .err_clear_i (clr0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // One table row = one clock cycle: bus inputs plus the watchdog phase
    // the design must be in during that cycle.
    typedef struct {
        logic cyc, stb, ack, err, rty;
        logic abort, fence;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic cyc, input logic stb, input logic ack,
                                input logic err, input logic rty,
                                input logic abort, input logic fence);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.rty = rty;
        v.abort = abort; v.fence = fence;
        vecs.push_back(v);
    endfunction

    function automatic logic [127:0] exp_vec(input vec_t v);
        logic fz;
        fz = v.fence;
        return {16'd0, BTE, SEL, CTI_INCR,
                v.ack & ~fz, v.abort | (v.err & ~fz), v.rty & ~fz, v.abort,
                v.cyc & ~fz, v.stb & ~fz, (fz ? 32'd0 : SDAT),
                ADR_A, 1'b1, MDAT};
    endfunction

    function automatic logic [127:0] got_vec();
        return {16'd0, s8.bte, s8.sel, s8.cti,
                m8.ack, m8.err, m8.rty, to8,
                s8.cyc, s8.stb, m8.dat_r,
                s8.adr, s8.we, s8.dat_w};
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    // Wait for the error pulse; returns the number of edges taken or -1
    task automatic wait_err(output int hit);
        hit = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (m8.err) begin
                hit = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        int hit;

        // ---------------- table ----------------
        // ack after 3 cycles
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // zero-latency err and rty pass straight through
        add(1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // silent slave: error on the 9th cycle, late acks swallowed
        for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 1, 1);
        add(1, 1, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // ack on the cycle the count reaches 8, then 4 beats 5 cycles apart
        for (int i = 0; i < 8; i++) add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 0, 0);
            add(1, 1, 1, 0, 0, 0, 0);
        end
        add(0, 0, 0, 0, 0, 0, 0);
        // master drops cyc during the abort cycle: straight back to idle
        for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);

        // ---------------- reset ----------------
        m8.dat_w = MDAT; m8.adr = ADR_A; m8.sel = SEL; m8.we = 1'b1;
        m8.cti = CTI_INCR; m8.bte = BTE; m8.cyc = 1'b1; m8.stb = 1'b1;
        s8.ack = 1'b0; s8.err = 1'b0; s8.rty = 1'b0; s8.dat_r = SDAT;
        m0.dat_w = MDAT; m0.adr = ADR_A; m0.sel = SEL; m0.we = 1'b0;
        m0.cti = CTI_CLASSIC; m0.bte = 2'b00; m0.cyc = 1'b0; m0.stb = 1'b0;
        s0.ack = 1'b0; s0.err = 1'b0; s0.rty = 1'b0; s0.dat_r = SDAT;
        clr8 = 1'b0; clr0 = 1'b0;

        #12;
        check("reset_state", 0,
              {91'd0, s8.stb, m8.err, to8, valid8, we8, adr8},
              {91'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        m8.cyc = 1'b0; m8.stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- table run ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            m8.cyc = vecs[i].cyc;
            m8.stb = vecs[i].stb;
            s8.ack = vecs[i].ack;
            s8.err = vecs[i].err;
            s8.rty = vecs[i].rty;
            #1;
            check("vec", i, got_vec(), exp_vec(vecs[i]));
            @(posedge clk);
            #1;
        end

        // ---------------- capture and clear ----------------
        check("capture", 0, {95'd0, valid8, we8, adr8},
              {95'd0, CAP, CAP, (CAP ? ADR_A : 32'd0)});
        clr8 = 1'b1;
        @(posedge clk);
        #1;
        clr8 = 1'b0;
        check("clear", 0, {127'd0, valid8}, 128'd0);

        // timeout with clear held high across the capture edge
        m8.adr = ADR_B; m8.we = 1'b0; m8.cti = CTI_CLASSIC;
        m8.cyc = 1'b1; m8.stb = 1'b1; clr8 = 1'b1;
        wait_err(hit);
        check("timeout_latency", 0, 128'(hit), 128'd9);
        check("timeout_pulse", 0, {124'd0, to8, m8.err, s8.stb, m8.ack},
              {124'd0, 4'b1100});
        check("clear_collision", 0, {95'd0, valid8, we8, adr8},
              {95'd0, CAP, 1'b0, (CAP ? ADR_B : 32'd0)});
        clr8 = 1'b0;
        @(posedge clk);
        #1;
        check("drain_fence", 0, {124'd0, to8, m8.err, s8.stb, s8.cyc}, 128'd0);

        // ---------------- asynchronous reset ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drain", 0,
              {91'd0, s8.stb, s8.cyc, to8, valid8, we8, adr8},
              {91'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_wait", 0, {124'd0, s8.stb, m8.err, to8, valid8},
              {124'd0, 4'b1000});
        @(negedge clk);
        rst_n = 1'b1;
        wait_err(hit);
        check("post_reset_latency", 0, 128'(hit), 128'd9);

        // recover: drop cyc in abort, then a 2-cycle-ack access
        m8.cyc = 1'b0; m8.stb = 1'b0;
        @(posedge clk);
        #1;
        m8.cyc = 1'b1; m8.stb = 1'b1; m8.cti = CTI_END;
        @(posedge clk);
        #1;
        s8.ack = 1'b1;
        #1;
        check("recover_ack", 0, {124'd0, m8.ack, m8.err, s8.stb, s8.cti == CTI_END},
              {124'd0, 4'b1011});
        @(posedge clk);
        #1;
        s8.ack = 1'b0; m8.cyc = 1'b0; m8.stb = 1'b0;

        // ---------------- TIMEOUT = 0 ----------------
        m0.cyc = 1'b1; m0.stb = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            check("wd_off", i,
                  {123'd0, m0.err, to0, s0.stb, s0.cyc, m0.dat_r == SDAT},
                  {123'd0, 5'b00111});
        end
        s0.ack = 1'b1;
        #1;
        check("wd_off_ack", 0, {126'd0, m0.ack, valid0}, {126'd0, 2'b10});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ct_bus_timeout.md
Name: ct_bus_timeout

Overview:
- Wishbone watchdog stage between the compute-tile CPU data master and the tile address-select stage; sits directly upstream of the select stage.
- Forwards every master cycle unchanged to the downstream bus.
- Counts cycles a strobe is outstanding without ack/err/rty. On expiry it terminates the transfer with a one-cycle error to the master and fences the downstream bus.
- Guarantees the CPU never hangs on an unmapped or dead slave.

Parameters:
- TIMEOUT, 255: cycles a strobe may wait for a response; 0 disables the watchdog (pure pass-through).
- CNT_W, $clog2(TIMEOUT+1) (min 1): counter width, derived, not overridden.

Ports:
- clk  in  1  tile clock
- rst_n  in  1  asynchronous active-low reset
- m_dat_i in 32, m_adr_i in 32, m_sel_i in 4, m_we_i in 1, m_cyc_i in 1, m_stb_i in 1, m_cti_i in 3, m_bte_i in 2: master request
- m_ack_o out 1, m_err_o out 1, m_rty_o out 1, m_dat_o out 32: response to master
- s_dat_o out 32, s_adr_o out 32, s_sel_o out 4, s_we_o out 1, s_cyc_o out 1, s_stb_o out 1, s_cti_o out 3, s_bte_o out 2: request to select stage
- s_ack_i in 1, s_err_i in 1, s_rty_i in 1, s_dat_i in 32: response from select stage
- timeout_o  out  1  one-cycle pulse coincident with the generated error
- err_adr_o  out  32  captured address of last timed-out access
- err_we_o  out  1  captured we of that access
- err_valid_o  out  1  capture register holds data
- err_clear_i  in  1  clears err_valid_o

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: FSM = IDLE, counter = 0, timeout_o = 0, err_valid_o = 0, err_adr_o = 0, err_we_o = 0.
- Pass-through:
  - dat/adr/sel/we/cti/bte always forwarded combinationally.
  - s_cyc_o = m_cyc_i & ~fence; s_stb_o = m_stb_i & ~fence.
  - In IDLE/WAIT, m_ack_o/m_rty_o/m_err_o/m_dat_o = slave signals, zero added latency.
- FSM states:
  - IDLE: counter = 0. If m_cyc_i & m_stb_i and no slave response this cycle -> WAIT, counter = 1.
  - WAIT:
    - On any slave ack/err/rty, counter = 0. Stay in WAIT if stb remains high (burst); else -> IDLE.
    - On stb low -> IDLE.
    - Otherwise counter += 1. When counter == TIMEOUT with no response -> ABORT.
  - ABORT (1 cycle):
    - fence = 1; m_err_o = 1, m_ack_o = 0, m_rty_o = 0, m_dat_o = 0; timeout_o = 1.
    - Slave response in this cycle is discarded.
    - -> DRAIN.
  - DRAIN:
    - fence = 1; master response outputs 0; late slave responses discarded.
    - When m_cyc_i == 0 -> IDLE.
- Timing: error appears exactly TIMEOUT+1 cycles after the first unacknowledged strobe cycle.
- Simultaneous events:
  - A slave response in the same cycle the counter reaches TIMEOUT wins. Response is passed and counter cleared; no ABORT.
  - Master dropping cyc during ABORT: ABORT still completes, then -> IDLE directly.
- Counter saturates, never wraps.
- TIMEOUT = 0: FSM held in IDLE, fence = 0 always, timeout_o = 0.
- Reset mid-operation: immediate return to IDLE, fence released, captured error cleared.

Optional Feature:
- Macro: CT_BUS_TIMEOUT_ERRCAPTURE_EN.
- With the macro:
  - On entering ABORT, err_adr_o <= m_adr_i, err_we_o <= m_we_i, err_valid_o <= 1.
  - A later timeout overwrites the capture.
  - err_clear_i clears err_valid_o only; timeout in the same cycle as err_clear_i wins (valid stays 1).
- Without the macro: err_adr_o = 0, err_we_o = 0, err_valid_o = 0 (constant); err_clear_i ignored.

Decomposition:
- Shared package ct_bus_pkg:
  - FSM state enum (IDLE, WAIT, ABORT, DRAIN).
  - Wishbone CTI constants (CLASSIC 3'b000, INCR 3'b010, END 3'b111).
  - Default TIMEOUT constant.
- One natural sub-module: ct_bus_timeout_cnt, a saturating counter with clear/enable and a terminal-count flag.
- FSM, fence and capture stay in the top.

Test Plan:
- TIMEOUT = 8, slave acks after 3 cycles:
  - m_ack_o pulse 3 cycles after stb; m_err_o and timeout_o never asserted.
- TIMEOUT = 8, slave never responds, adr 0x7000_0040, we = 1:
  - m_err_o and timeout_o high for exactly 1 cycle, 9 cycles after stb rises.
  - s_stb_o = 0 from that cycle until m_cyc_i = 0.
  - With the macro: err_adr_o = 0x7000_0040, err_we_o = 1, err_valid_o = 1.
- TIMEOUT = 8, slave acks on the cycle the counter reaches 8:
  - m_ack_o passed; no error.
  - A following 4-beat INCR burst with 5-cycle gaps completes without error.
- Slave ack arrives in ABORT and in DRAIN:
  - m_ack_o stays 0.
  - FSM returns to IDLE after m_cyc_i drops.
  - Next access with 2-cycle ack succeeds.
- rst_n pulsed low while in WAIT (counter = 5):
  - All outputs at reset values asynchronously; s_stb_o follows m_stb_i after release.
- TIMEOUT = 0, slave silent for 1000 cycles:
  - No error, no fence.
  - Clearing: err_clear_i in the same cycle as a new timeout leaves err_valid_o = 1.
